// File: rtl/memory_access_unit_if.sv
// Request/response handshake and dataRAM bus bundle for memory_access_unit.
// Ports: request*/response* processor side, ram* dataRAM side.
interface memory_access_unit_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
);
  logic                     requestValid;
  logic                     requestReady;
  logic                     requestWrite;
  logic                     requestByte;
  logic [ADDRESS_WIDTH-1:0] requestAddress;
  logic [1:0]               requestByteSelect;
  logic [DATA_WIDTH-1:0]    requestData;
  logic                     responseValid;
  logic [DATA_WIDTH-1:0]    responseData;
  logic                     responseError;
  logic [ADDRESS_WIDTH-1:0] ramAddress;
  logic                     ramWriteEnable;
  logic [DATA_WIDTH-1:0]    ramDataC;
  logic [DATA_WIDTH-1:0]    ramDataIn;

  modport slave (
    input  requestValid, requestWrite,
    input  requestByte, requestAddress,
    input  requestByteSelect, requestData,
    input  ramDataIn,
    output requestReady, responseValid,
    output responseData, responseError,
    output ramAddress, ramWriteEnable,
    output ramDataC
  );

  modport master (
    output requestValid, requestWrite,
    output requestByte, requestAddress,
    output requestByteSelect, requestData,
    output ramDataIn,
    input  requestReady, responseValid,
    input  responseData, responseError,
    input  ramAddress, ramWriteEnable,
    input  ramDataC
  );
endinterface

// File: rtl/memory_access_unit.sv
// Load/store initiator for a single-port dataRAM (word/byte, RMW stores).
// Ports: clock, resetN (async active-low), bus (memory_access_unit_if.slave).
module memory_access_unit #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int RAM_DEPTH     = 51,
  parameter int READ_LATENCY  = 0
) (
  input logic                 clock,
  input logic                 resetN,
  memory_access_unit_if.slave bus
);

  localparam int CW =
    (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_LATENCY);
  localparam logic [ADDRESS_WIDTH:0] DEPTH =
    (ADDRESS_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] LOW_MASK =
    DATA_WIDTH'(8'hFF);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESPOND
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addrQ;
  logic                     writeQ;
  logic                     byteQ;
  logic [1:0]               laneQ;
  logic [DATA_WIDTH-1:0]    dataQ;
  logic [CW-1:0]            waitCnt;

  logic                     addrBad;
  logic [4:0]               shiftAmt;
  logic [DATA_WIDTH-1:0]    byteLoad;
  logic [DATA_WIDTH-1:0]    merged;

  assign addrBad = {1'b0, bus.requestAddress} >= DEPTH;

  // Lane extract for byte loads and lane merge for byte stores.
  always_comb begin
    shiftAmt = {laneQ, 3'b000};
    byteLoad = (bus.ramDataIn >> shiftAmt) & LOW_MASK;
    merged   = (bus.ramDataIn & ~(LOW_MASK << shiftAmt))
             | ((dataQ & LOW_MASK) << shiftAmt);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      addrQ              <= '0;
      writeQ             <= 1'b0;
      byteQ              <= 1'b0;
      laneQ              <= '0;
      dataQ              <= '0;
      waitCnt            <= '0;
      bus.requestReady   <= 1'b1;
      bus.responseValid  <= 1'b0;
      bus.responseData   <= '0;
      bus.responseError  <= 1'b0;
      bus.ramAddress     <= '0;
      bus.ramWriteEnable <= 1'b0;
      bus.ramDataC       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.requestValid && bus.requestReady) begin
            addrQ            <= bus.requestAddress;
            writeQ           <= bus.requestWrite;
            byteQ            <= bus.requestByte;
            laneQ            <= bus.requestByteSelect;
            dataQ            <= bus.requestData;
            waitCnt          <= '0;
            bus.requestReady <= 1'b0;
            if (addrBad) begin
              bus.responseValid <= 1'b1;
              bus.responseError <= 1'b1;
              bus.responseData  <= '0;
              state             <= RESPOND;
            end else if (bus.requestWrite && !bus.requestByte) begin
              bus.ramAddress     <= bus.requestAddress;
              bus.ramDataC       <= bus.requestData;
              bus.ramWriteEnable <= 1'b1;
              state              <= WRITE;
            end else begin
              bus.ramAddress <= bus.requestAddress;
              state          <= READ;
            end
          end
        end
        READ: begin
          if (waitCnt == WAIT_LAST) begin
            if (writeQ) begin
              bus.ramDataC       <= merged;
              bus.ramWriteEnable <= 1'b1;
              state              <= WRITE;
            end else begin
              bus.responseValid <= 1'b1;
              bus.responseError <= 1'b0;
              bus.responseData  <=
                byteQ ? byteLoad : bus.ramDataIn;
              state             <= RESPOND;
            end
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        WRITE: begin
          bus.ramWriteEnable <= 1'b0;
          bus.responseValid  <= 1'b1;
          bus.responseError  <= 1'b0;
          bus.responseData   <= '0;
          state              <= RESPOND;
        end
        RESPOND: begin
          bus.responseValid <= 1'b0;
          bus.responseError <= 1'b0;
          bus.responseData  <= '0;
          bus.requestReady  <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench: two units (READ_LATENCY 0 and 2) on modelled RAMs.
// Ports: drives both bus interfaces, shared clock and resetN.
module tb_memory_access_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetN;
  logic        clearRam;
  logic        sel;
  logic        reqValid;
  logic        reqWrite;
  logic        reqByte;
  logic [9:0]  reqAddr;
  logic [1:0]  reqLane;
  logic [31:0] reqData;

  int tests  = 0;
  int failed = 0;

  memory_access_unit_if #(
    .ADDRESS_WIDTH(10), .DATA_WIDTH(32)
  ) bus0 ();
  memory_access_unit_if #(
    .ADDRESS_WIDTH(10), .DATA_WIDTH(32)
  ) bus2 ();

  memory_access_unit #(.READ_LATENCY(0)) dut0 (
    .clock(clock), .resetN(resetN), .bus(bus0)
  );
  memory_access_unit #(.READ_LATENCY(2)) dut2 (
    .clock(clock), .resetN(resetN), .bus(bus2)
  );

  assign bus0.requestValid      = reqValid & ~sel;
  assign bus2.requestValid      = reqValid & sel;
  assign bus0.requestWrite      = reqWrite;
  assign bus2.requestWrite      = reqWrite;
  assign bus0.requestByte       = reqByte;
  assign bus2.requestByte       = reqByte;
  assign bus0.requestAddress    = reqAddr;
  assign bus2.requestAddress    = reqAddr;
  assign bus0.requestByteSelect = reqLane;
  assign bus2.requestByteSelect = reqLane;
  assign bus0.requestData       = reqData;
  assign bus2.requestData       = reqData;

  // dataRAM models: combinational read, write on the clock edge.
  logic [31:0] ram0 [0:1023];
  logic [31:0] ram2 [0:1023];
  assign bus0.ramDataIn = ram0[bus0.ramAddress];
  assign bus2.ramDataIn = ram2[bus2.ramAddress];

  always @(posedge clock) begin
    if (clearRam) begin
      for (int i = 0; i < 1024; i++) begin
        ram0[i] <= '0;
        ram2[i] <= '0;
      end
    end else begin
      if (bus0.ramWriteEnable)
        ram0[bus0.ramAddress] <= bus0.ramDataC;
      if (bus2.ramWriteEnable)
        ram2[bus2.ramAddress] <= bus2.ramDataC;
    end
  end

  // Reference memory contents, updated per completed transaction.
  logic [31:0] model0 [0:50];
  logic [31:0] model2 [0:50];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic txn(input logic s, input logic w,
                     input logic b, input int a,
                     input logic [1:0] lane,
                     input logic [31:0] d,
                     output logic [31:0] got,
                     output int waits);
    bit          err;
    int          expLat, lat, weCnt, weCyc, lim;
    logic [31:0] old, expData, expWord;
    logic [31:0] weAddr, weData, gotErr;
    logic        rv, we, rdy, busyRdy;
    err     = (a >= 51);
    old     = err ? 32'h0 : (s ? model2[a] : model0[a]);
    lim     = s ? 2 : 0;
    expData = 32'h0;
    expWord = old;
    if (err) expLat = 1;
    else if (w && !b) begin
      expLat  = 2;
      expWord = d;
    end else if (!w) begin
      expLat  = 2 + lim;
      expData = b ? ((old >> (8 * lane)) & 32'hFF) : old;
    end else begin
      expLat = 3 + lim;
      expWord[8 * lane +: 8] = d[7:0];
    end
    sel      = s;
    reqValid = 1'b1;
    reqWrite = w;
    reqByte  = b;
    reqAddr  = a[9:0];
    reqLane  = lane;
    reqData  = d;
    waits    = 0;
    rdy = s ? bus2.requestReady : bus0.requestReady;
    while (!rdy && waits < 20) begin
      @(negedge clock);
      waits++;
      rdy = s ? bus2.requestReady : bus0.requestReady;
    end
    check("accept", {31'b0, waits < 20}, 32'd1);
    @(posedge clock);
    #1;
    // Valid stays high and fields change while busy.
    reqWrite = 1'($urandom);
    reqByte  = 1'($urandom);
    reqAddr  = 10'($urandom);
    reqLane  = 2'($urandom);
    reqData  = $urandom;
    lat = 0; weCnt = 0; weCyc = 0;
    weAddr = 0; weData = 0; got = 'x; gotErr = 'x;
    busyRdy = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      rv  = s ? bus2.responseValid : bus0.responseValid;
      we  = s ? bus2.ramWriteEnable : bus0.ramWriteEnable;
      rdy = s ? bus2.requestReady : bus0.requestReady;
      if (rdy) busyRdy = 1'b1;
      if (we) begin
        weCnt++;
        weCyc  = n;
        weAddr = 32'(s ? bus2.ramAddress : bus0.ramAddress);
        weData = s ? bus2.ramDataC : bus0.ramDataC;
      end
      if (rv) begin
        lat    = n;
        got    = s ? bus2.responseData : bus0.responseData;
        gotErr = {31'b0, s ? bus2.responseError
                           : bus0.responseError};
        break;
      end
    end
    reqValid = 1'b0;
    check("latency", lat, expLat);
    check("respErr", gotErr, {31'b0, err});
    check("respData", got, expData);
    check("busyReady", {31'b0, busyRdy}, 32'd0);
    check("writeCount", weCnt, (w && !err) ? 1 : 0);
    if (w && !err) begin
      check("writeCycle", weCyc, expLat - 1);
      check("writeAddr", weAddr, a);
      check("writeData", weData, expWord);
      if (s) model2[a] = expWord;
      else   model0[a] = expWord;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int          w;
    int          a;
    for (int i = 0; i < 51; i++) begin
      model0[i] = '0;
      model2[i] = '0;
    end
    resetN   = 1'b0;
    clearRam = 1'b1;
    sel      = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqByte  = 1'b0;
    reqAddr  = '0;
    reqLane  = '0;
    reqData  = '0;
    repeat (2) @(negedge clock);
    check("rstReady0", {31'b0, bus0.requestReady}, 1);
    check("rstReady2", {31'b0, bus2.requestReady}, 1);
    check("rstWe0", {31'b0, bus0.ramWriteEnable}, 0);
    check("rstWe2", {31'b0, bus2.ramWriteEnable}, 0);
    check("rstRv0", {31'b0, bus0.responseValid}, 0);
    check("rstAddr0", 32'(bus0.ramAddress), 0);
    check("rstDataC0", bus0.ramDataC, 0);
    check("rstRd0", bus0.responseData, 0);
    clearRam = 1'b0;
    resetN   = 1'b1;
    @(negedge clock);

    txn(0, 1, 0, 5, 0, 32'h12345678, got, w);
    check("st5Resp", got, 32'h0);
    txn(0, 0, 0, 5, 0, 0, got, w);
    check("ld5", got, 32'h12345678);
    txn(0, 1, 1, 5, 2, 32'h000000AB, got, w);
    txn(0, 0, 0, 5, 0, 0, got, w);
    check("ld5Merge", got, 32'h12AB5678);
    txn(0, 0, 1, 5, 3, 0, got, w);
    check("ldB3", got, 32'h00000012);
    txn(0, 0, 1, 5, 0, 0, got, w);
    check("ldB0", got, 32'h00000078);
    txn(0, 1, 0, 50, 0, 32'hDEADBEEF, got, w);
    txn(0, 0, 0, 50, 0, 0, got, w);
    check("ld50", got, 32'hDEADBEEF);
    txn(0, 0, 0, 51, 0, 0, got, w);
    txn(0, 1, 0, 51, 0, 32'h55555555, got, w);
    txn(0, 1, 1, 1023, 1, 32'h11, got, w);
    txn(0, 1, 1, 5, 3, 32'hFFFFFFEE, got, w);
    txn(0, 0, 0, 5, 0, 0, got, w);
    check("ld5Lane3", got, 32'hEEAB5678);

    txn(1, 1, 0, 5, 0, 32'h12345678, got, w);
    txn(1, 0, 0, 5, 0, 0, got, w);
    check("lat2Ld5", got, 32'h12345678);
    txn(1, 1, 1, 5, 1, 32'h9C, got, w);
    txn(1, 0, 0, 5, 0, 0, got, w);
    check("lat2Merge", got, 32'h12349C78);
    txn(1, 0, 0, 51, 0, 0, got, w);

    txn(0, 1, 0, 10, 0, 32'd7, got, w);
    txn(0, 0, 0, 10, 0, 0, got, w);
    check("b2bData", got, 32'd7);
    check("b2bWait", w, 1);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0)
        a = int'($urandom_range(51, 1023));
      else
        a = int'($urandom_range(0, 50));
      txn(1'($urandom), 1'($urandom), 1'($urandom),
          a, 2'($urandom), $urandom, got, w);
    end

    txn(0, 1, 0, 20, 0, 32'hCAFEF00D, got, w);
    sel      = 1'b0;
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqByte  = 1'b1;
    reqAddr  = 10'd20;
    reqLane  = 2'd1;
    reqData  = 32'h55;
    @(negedge clock);
    check("midReady", {31'b0, bus0.requestReady}, 1);
    @(posedge clock);
    #1 reqValid = 1'b0;
    @(negedge clock);
    resetN = 1'b0;
    #1;
    check("midWe", {31'b0, bus0.ramWriteEnable}, 0);
    check("midRdy", {31'b0, bus0.requestReady}, 1);
    check("midAddr", 32'(bus0.ramAddress), 0);
    @(negedge clock);
    check("midWeHeld", {31'b0, bus0.ramWriteEnable}, 0);
    resetN = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("postWe", {31'b0, bus0.ramWriteEnable}, 0);
    end
    txn(0, 0, 0, 20, 0, 0, got, w);
    check("ldAfterAbort", got, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
